// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped countdown timer on the CPU data bus, downstream of the
// memory stage. It takes the bridge-qualified store stream, returns
// combinational read data for loads and drives one HWInt line into CP0.
//
// Register window (offset = addr - BASE_ADDR, 16 bytes, addr[1:0] ignored):
//   0x0 CTRL     bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0
//   0x4 PRESET   reload value, read/write
//   0x8 COUNT    current count, read-only
//   0xC PRESCALE 16-bit step divider (only with TIMER_PRESCALE_EN),
//                otherwise reads 0 and ignores writes
//
// Build option:
//   TIMER_PRESCALE_EN  adds PRESCALE and an internal divider so that each
//                      COUNT step takes PRESCALE+1 cycles. Undefined by
//                      default, in which case COUNT steps every cycle.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     asynchronous, active-low reset
//   addr      byte address from the memory stage
//   we        store strobe from the bridge
//   byteen    per-byte write enables (write only when we && byteen != 0)
//   wdata     store data, lanes aligned with byteen
//   rdata     combinational read data for addr
//   irq       interrupt request (irqFlag & CTRL.IM)
//   dbgState  current FSM state (0 IDLE, 1 LOAD, 2 CNT, 3 INT)
//
// Bus handshake: there is no valid/ready pair. A store is accepted on the
// rising edge where we==1 and byteen!=0; a load is served in the same cycle
// from rdata with no wait states.
// ---------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timerState_e;

    timerState_e state;
    timerState_e nextState;

    // Architectural registers
    logic [3:0]  ctrlReg;
    logic [31:0] presetReg;
    logic [31:0] countReg;
    logic        irqFlag;

    // Decoded CTRL fields
    logic ctrlEn;
    logic ctrlIm;
    logic autoReload;

    assign ctrlEn     = ctrlReg[0];
    assign ctrlIm     = ctrlReg[3];
    // Only MODE==01 reloads; 10 and 11 fall back to one-shot.
    assign autoReload = (ctrlReg[2:1] == 2'b01);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] offset;
    logic        inWindow;
    logic        selCtrl;
    logic        selPreset;
    logic        selPrescale;
    logic        wrActive;

    // A single unsigned compare covers both sides of the window: addresses
    // below BASE_ADDR wrap to large offsets and fall outside.
    assign offset      = addr - BASE_ADDR;
    assign inWindow    = (offset < 32'd16);
    assign selCtrl     = inWindow && (offset[3:2] == 2'd0);
    assign selPreset   = inWindow && (offset[3:2] == 2'd1);
    assign selPrescale = inWindow && (offset[3:2] == 2'd3);
    assign wrActive    = we && (byteen != 4'b0000);

    // ------------------------------------------------------------------
    // Optional prescaler
    // ------------------------------------------------------------------
    // stepTick marks the CNT cycles on which COUNT is allowed to move.
    logic stepTick;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescaleReg;
    logic [15:0] divider;

    assign stepTick = (divider == 16'd0);
`else
    assign stepTick = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (ctrlEn) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                nextState = CNT;
            end
            CNT: begin
                if (!ctrlEn) begin
                    nextState = IDLE;
                end else if (stepTick && (countReg <= 32'd1)) begin
                    nextState = INT;
                end
            end
            INT: begin
                // Both modes pass through IDLE; auto-reload re-enters LOAD
                // from there because EN is left set.
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output (control strobe) logic
    // ------------------------------------------------------------------
    logic loadCount;   // COUNT <= PRESET, irqFlag <= 0
    logic decCount;    // COUNT <= COUNT - 1
    logic expire;      // COUNT <= 0, irqFlag <= 1
    logic oneShotDone; // CTRL.EN <= 0 (unless the CPU writes CTRL)
    logic pulseClear;  // irqFlag <= 0 after a one-cycle auto-reload pulse
    logic divReload;   // divider <= PRESCALE
    logic divDec;      // divider <= divider - 1

    always_comb begin
        loadCount   = 1'b0;
        decCount    = 1'b0;
        expire      = 1'b0;
        oneShotDone = 1'b0;
        pulseClear  = 1'b0;
        divReload   = 1'b0;
        divDec      = 1'b0;
        unique case (state)
            IDLE: begin
            end
            LOAD: begin
                loadCount = 1'b1;
                divReload = 1'b1;
            end
            CNT: begin
                if (ctrlEn) begin
                    if (stepTick) begin
                        divReload = 1'b1;
                        // PRESET==0 lands here on the first step as well,
                        // so it behaves like PRESET==1.
                        if (countReg <= 32'd1) begin
                            expire = 1'b1;
                        end else begin
                            decCount = 1'b1;
                        end
                    end else begin
                        divDec = 1'b1;
                    end
                end
            end
            INT: begin
                if (autoReload) begin
                    pulseClear = 1'b1;
                end else begin
                    oneShotDone = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // CTRL: the CPU write wins over the FSM clearing EN in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlReg <= 4'h0;
        end else if (wrActive && selCtrl) begin
            // Only byte lane 0 carries implemented bits.
            if (byteen[0]) begin
                ctrlReg <= wdata[3:0];
            end
        end else if (oneShotDone) begin
            ctrlReg[0] <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PRESET: byte-merged writes; only sampled by the FSM in LOAD, so a
    // write during counting affects the next period only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presetReg <= 32'h0;
        end else if (wrActive && selPreset) begin
            for (int i = 0; i < 4; i++) begin
                if (byteen[i]) begin
                    presetReg[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // COUNT: owned by the FSM only; bus writes to it are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg <= 32'h0;
        end else if (loadCount) begin
            countReg <= presetReg;
        end else if (expire) begin
            countReg <= 32'h0;
        end else if (decCount) begin
            countReg <= countReg - 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt flag: set on expiry, cleared on LOAD or after the
    // auto-reload pulse. In one-shot mode it persists until the next LOAD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irqFlag <= 1'b0;
        end else if (loadCount) begin
            irqFlag <= 1'b0;
        end else if (expire) begin
            irqFlag <= 1'b1;
        end else if (pulseClear) begin
            irqFlag <= 1'b0;
        end
    end

`ifdef TIMER_PRESCALE_EN
    // ------------------------------------------------------------------
    // PRESCALE register and step divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaleReg <= 16'h0;
        end else if (wrActive && selPrescale) begin
            if (byteen[0]) begin
                prescaleReg[7:0] <= wdata[7:0];
            end
            if (byteen[1]) begin
                prescaleReg[15:8] <= wdata[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divider <= 16'h0;
        end else if (divReload) begin
            divider <= prescaleReg;
        end else if (divDec) begin
            divider <= divider - 16'd1;
        end
    end
`else
    // Divider strobes have no consumer without the prescaler.
    logic unusedDiv;
    assign unusedDiv = divReload | divDec | selPrescale;
`endif

    // ------------------------------------------------------------------
    // Read mux (zero-latency)
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        if (inWindow) begin
            unique case (offset[3:2])
                2'd0: rdata = {28'h0, ctrlReg};
                2'd1: rdata = presetReg;
                2'd2: rdata = countReg;
`ifdef TIMER_PRESCALE_EN
                2'd3: rdata = {16'h0, prescaleReg};
`else
                2'd3: rdata = {31'h0, unusedDiv & 1'b0};
`endif
                default: rdata = 32'h0;
            endcase
        end
    end

    assign irq      = irqFlag & ctrlIm;
    assign dbgState = state;

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// Testbench for timer_counter. The driver issues bus writes and, for each
// cycle, queues the values it expects to observe (rdata for the current
// addr, irq, FSM state). A separate monitor pops and compares them on the
// falling edge of that same cycle.
// ---------------------------------------------------------------------------
module tb_timer_counter;

    localparam logic [31:0] BASE    = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL  = BASE + 32'h0;
    localparam logic [31:0] A_PRE   = BASE + 32'h4;
    localparam logic [31:0] A_CNT   = BASE + 32'h8;
    localparam logic [31:0] A_PSC   = BASE + 32'hC;
    localparam logic [31:0] A_OUT   = BASE + 32'h10;
    localparam logic [31:0] A_BELOW = BASE - 32'h4;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_ST  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  dbgState;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we       (we),
        .byteen   (byteen),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .dbgState (dbgState)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          probe_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] act;
        int          k;
        string       nm;
        for (int i = 0; i < probe_cnt; i++) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL queue_underflow: got empty queue required %0d entries", probe_cnt);
            end else begin
                e  = exp_q.pop_front();
                k  = kind_q.pop_front();
                nm = name_q.pop_front();
                case (k)
                    K_RD:    act = rdata;
                    K_IRQ:   act = {31'h0, irq};
                    default: act = {30'h0, dbgState};
                endcase
                n_cmp++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", nm, act, e, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        probe_cnt = 0;
    endtask

    task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
        exp_q.push_back(v);
        kind_q.push_back(kind);
        name_q.push_back(nm);
        probe_cnt++;
    endtask

    task automatic chk_rd(input logic [31:0] a, input logic [31:0] v, input string nm);
        addr = a;
        expect_v(K_RD, v, nm);
    endtask

    task automatic chk_irq(input logic [31:0] v, input string nm);
        expect_v(K_IRQ, v, nm);
    endtask

    task automatic chk_st(input logic [31:0] v, input string nm);
        expect_v(K_ST, v, nm);
    endtask

    // Drives a store for one cycle; returns just after the edge that
    // performed it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        byteen = 4'h0;
        wdata  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; addr = 32'h0; we = 1'b0; byteen = 4'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk_rd(A_CTRL, 32'h0, "rst_ctrl"); chk_irq(0, "rst_irq"); chk_st(0, "rst_state");
        tick();
        reset = 1'b1;
        chk_rd(A_PRE, 32'h0, "rst_preset");
        tick();
        chk_rd(A_CNT, 32'h0, "rst_count"); chk_st(0, "rst_state_idle");
        tick();

        // Byte merge on CTRL (also starts the timer, stopped right after)
        wr(A_CTRL, 32'hFFFF_FFFF, 4'b0001);
        chk_rd(A_CTRL, 32'h0000_000F, "bm_ctrl");
        tick();
        wr(A_CTRL, 32'h0, 4'b1111);
        chk_st(2, "bm_state_cnt"); chk_rd(A_CTRL, 32'h0, "bm_ctrl_clr");
        tick();
        chk_st(0, "bm_state_idle"); chk_irq(0, "bm_irq");
        tick();
        wr(A_PRE, 32'h1234_5678, 4'b1100);
        chk_rd(A_PRE, 32'h1234_0000, "bm_preset_hi");
        tick();
        wr(A_PRE, 32'hAABB_CCDD, 4'b0011);
        chk_rd(A_PRE, 32'h1234_CCDD, "bm_preset_lo");
        tick();

        // Reset asserted mid-count
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);          // e0
        tick();                            // e1 LOAD
        tick();                            // e2
        chk_rd(A_CNT, 32'd5, "mid_count5");
        tick();                            // e3
        chk_rd(A_CNT, 32'd4, "mid_count4");
        tick();                            // e4
        reset = 1'b0;
        chk_rd(A_CNT, 32'h0, "mid_rst_count"); chk_irq(0, "mid_rst_irq"); chk_st(0, "mid_rst_state");
        tick();
        chk_rd(A_CTRL, 32'h0, "mid_rst_ctrl");
        tick();
        chk_rd(A_PRE, 32'h0, "mid_rst_preset");
        tick();
        reset = 1'b1;
        chk_st(0, "mid_rel_state"); chk_rd(A_COUNT_OR(A_CNT), 32'h0, "mid_rel_count");
        tick();
        chk_st(0, "mid_rel_state2");
        tick();

        // One-shot, IM=1, PRESET=5
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);          // e0
        chk_st(0, "os_e0_state"); chk_rd(A_CTRL, 32'h9, "os_e0_ctrl");
        tick();                            // e1
        chk_st(1, "os_e1_load");
        tick();                            // e2
        chk_rd(A_CNT, 32'd5, "os_e2_count"); chk_st(2, "os_e2_cnt");
        tick(); tick(); tick(); tick();    // e6
        chk_rd(A_CNT, 32'd1, "os_e6_count"); chk_irq(0, "os_e6_irq");
        tick();                            // e7
        chk_irq(1, "os_e7_irq"); chk_st(3, "os_e7_int"); chk_rd(A_CNT, 32'd0, "os_e7_count");
        tick();                            // e8
        chk_irq(1, "os_e8_irq"); chk_rd(A_CTRL, 32'h8, "os_e8_ctrl"); chk_st(0, "os_e8_idle");
        tick();                            // e9
        chk_irq(1, "os_e9_irq_hold"); chk_st(0, "os_e9_idle");
        tick();

        // Collision: CPU rewrites CTRL in the INT cycle
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);          // e0
        chk_irq(1, "col_e0_irq_stale");
        tick();                            // e1
        chk_st(1, "col_e1_load"); chk_irq(1, "col_e1_irq");
        tick();                            // e2
        chk_st(2, "col_e2_cnt"); chk_rd(A_CNT, 32'd2, "col_e2_count"); chk_irq(0, "col_e2_irq");
        tick();                            // e3
        chk_rd(A_CNT, 32'd1, "col_e3_count");
        tick();                            // e4
        chk_st(3, "col_e4_int"); chk_irq(1, "col_e4_irq");
        wr(A_CTRL, 32'h9, 4'hF);          // e5
        chk_st(0, "col_e5_idle"); chk_rd(A_CTRL, 32'h9, "col_e5_ctrl_en"); chk_irq(1, "col_e5_irq");
        tick();                            // e6
        chk_st(1, "col_e6_load"); chk_irq(1, "col_e6_irq");
        tick();                            // e7
        chk_st(2, "col_e7_cnt"); chk_irq(0, "col_e7_irq_clr");
        wr(A_CTRL, 32'h0, 4'hF);          // e8
        chk_rd(A_CNT, 32'd1, "col_e8_count"); chk_st(2, "col_e8_cnt");
        tick();                            // e9
        chk_st(0, "col_e9_idle"); chk_rd(A_CNT, 32'd1, "col_e9_count_hold"); chk_irq(0, "col_e9_irq");
        tick();

        // Auto-reload, PRESET=3: pulse after e5, e11, e17
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);          // e0
        for (int k = 0; k <= 18; k++) begin
            if (k >= 5 && ((k - 5) % 6) == 0) begin
                chk_irq(1, $sformatf("ar_irq_e%0d", k));
                chk_st(3, $sformatf("ar_int_e%0d", k));
            end else begin
                chk_irq(0, $sformatf("ar_irq_e%0d", k));
            end
            tick();
        end
        wr(A_CTRL, 32'h0, 4'hF);          // e20
        chk_st(2, "ar_e20_cnt"); chk_rd(A_CNT, 32'd3, "ar_e20_count");
        tick();                            // e21
        chk_st(0, "ar_e21_idle"); chk_irq(0, "ar_e21_irq");
        tick();

        // Masking: IM=0, one-shot, PRESET=0
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);          // e0
        tick();                            // e1
        chk_st(1, "mk_e1_load");
        tick();                            // e2
        chk_st(2, "mk_e2_cnt"); chk_rd(A_CNT, 32'd0, "mk_e2_count");
        tick();                            // e3
        chk_st(3, "mk_e3_int"); chk_irq(0, "mk_e3_irq_masked"); chk_rd(A_CNT, 32'd0, "mk_e3_count");
        tick();                            // e4
        chk_st(0, "mk_e4_idle"); chk_rd(A_CTRL, 32'h0, "mk_e4_ctrl"); chk_irq(0, "mk_e4_irq");
        tick();
        wr(A_CTRL, 32'h8, 4'hF);
        chk_irq(1, "mk_unmask_irq"); chk_rd(A_CTRL, 32'h8, "mk_unmask_ctrl");
        tick();
        wr(A_CTRL, 32'h0, 4'hF);
        chk_irq(0, "mk_remask_irq");
        tick();

        // Read-only COUNT and out-of-window accesses
        wr(A_CNT, 32'hDEAD_BEEF, 4'hF);
        chk_rd(A_CNT, 32'd0, "oow_count_ro");
        tick();
        wr(A_OUT, 32'hFFFF_FFFF, 4'hF);
        chk_rd(A_OUT, 32'h0, "oow_above_rd");
        tick();
        chk_rd(A_CTRL, 32'h0, "oow_ctrl_intact");
        tick();
        chk_rd(A_PRE, 32'h0, "oow_preset_intact");
        tick();
        wr(A_BELOW, 32'hFFFF_FFFF, 4'hF);
        chk_rd(A_BELOW, 32'h0, "oow_below_rd");
        tick();
        wr(A_PSC, 32'hFFFF_FFFF, 4'hF);
`ifdef TIMER_PRESCALE_EN
        chk_rd(A_PSC, 32'h0000_FFFF, "psc_rd");
`else
        chk_rd(A_PSC, 32'h0, "psc_absent_rd");
`endif
        tick();
        chk_st(0, "end_idle"); chk_irq(0, "end_irq");
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic [31:0] A_COUNT_OR(input logic [31:0] a);
        return a;
    endfunction

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped countdown timer on the data-bus side of the pipelined CPU, downstream of the memory stage.
- It consumes the memory-stage store stream (m_data_addr / m_data_wdata / m_data_byteen, gated by the system bridge into we) and returns read data for loads.
- It produces one bit of the CPU's 6-bit HWInt vector that feeds CP0.
- It holds three 32-bit registers: CTRL, PRESET and COUNT.

Parameters:
- BASE_ADDR, 32'h0000_7F00: word-aligned base of the 16-byte register window.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (clears on reset==0, independent of clk).
- addr  input  32  byte address from memory stage; bits [1:0] ignored.
- we  input  1  store strobe from bridge, already qualified by the memory stage.
- byteen  input  4  per-byte write enables; a write happens only when we==1 and byteen!=0.
- wdata  input  32  store data, byte lanes aligned per byteen.
- rdata  output  32  combinational read data for addr.
- irq  output  1  interrupt request to HWInt.

Behaviour:
- Address map (offset = addr - BASE_ADDR):
  - 0x0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0 and ignore writes.
  - 0x4 PRESET.
  - 0x8 COUNT: read-only; writes ignored.
  - Any other offset, or an address outside the window: rdata=0 and writes ignored.
- Writes merge per byte: reg[8i+7:8i] <= wdata[8i+7:8i] for each i with byteen[i]==1.
- rdata is purely combinational, with zero-cycle latency.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Outputs: irq=0; rdata reflects the zeroed registers.
- irq = irq_flag & CTRL.IM.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; irq_flag <= 0; go to CNT.
  - CNT, EN==0: go to IDLE; COUNT holds.
  - CNT, COUNT>1: COUNT <= COUNT-1.
  - CNT, COUNT<=1: COUNT <= 0; irq_flag <= 1; go to INT.
  - INT, MODE==00 (one-shot): CTRL.EN <= 0; go to IDLE; irq_flag stays 1 until the next LOAD.
  - INT, MODE==01 (auto-reload): irq_flag <= 0 (irq is a 1-cycle pulse); go to IDLE; EN is untouched, so the timer reloads.
  - MODE 10/11 behave as 00.
- Latency, with the EN=1 write at edge e0 and PRESET=P, P>=1:
  - LOAD at e1; CNT with COUNT=P at e2.
  - INT with irq=1 after edge e(P+2).
  - Auto-reload period is P+3 cycles.
- PRESET=0 behaves like P=1.
- Writing PRESET while counting affects only the next LOAD.
- Simultaneous events: a CPU write to CTRL in the same cycle as the FSM's EN clear in INT is resolved in favour of the CPU write (its byte-merged value is stored).
- Writing EN=0 while in INT: the INT transition completes, then the FSM stays in IDLE.
- Asserting reset mid-count immediately returns all state to reset values.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- When defined:
  - Adds a PRESCALE register at offset 0x8+4=0xC, 16 bits, read/write, upper 16 bits read 0.
  - Adds an internal 16-bit divider, reloaded in LOAD.
  - In CNT, COUNT changes only on cycles where the divider equals 0; otherwise the divider decrements.
  - Each COUNT step therefore takes PRESCALE+1 cycles.
  - PRESCALE resets to 0.
- Without it: offset 0xC reads 0 and ignores writes; COUNT steps every cycle, identical to PRESCALE=0.

Test Plan:
- Reset: hold reset=0 mid-count with PRESET=5 running -> irq=0 and CTRL/PRESET/COUNT read 0 immediately; state is IDLE after release.
- One-shot, IM=1: write PRESET=5, then CTRL=0x9 at e0 -> COUNT reads 5 after e2 and 1 after e6; irq=1 after e7 and stays 1; CTRL reads 0x8 after e8.
- Auto-reload: PRESET=3, CTRL=0xB -> irq high for exactly 1 cycle every 6 cycles across 3 periods.
- Byte merge: write CTRL=0xFFFF_FFFF with byteen=4'b0001 -> CTRL reads 0x0000_000F; write PRESET=0x1234_5678 with byteen=4'b1100 -> PRESET reads 0x1234_0000.
- Masking/boundary: IM=0 with one-shot PRESET=0 -> irq stays 0, and COUNT reads 0 one cycle after CNT is entered; write to COUNT or to BASE_ADDR+0x10 -> no register change, rdata=0 at the out-of-window address.
- Collision: in the INT cycle of a one-shot, write CTRL=0x9 -> EN stays 1, the FSM reloads, and irq_flag clears at LOAD.
